// File: rtl/vend_ctrl.sv
// Vending sequencer: accumulates coin credit, arbitrates product selection,
// holds the release request until ack or timeout, then pays change one coin per cycle.
module vend_ctrl #(
  parameter int CREDIT_W    = 6,
  parameter int PRICE_A     = 15,
  parameter int PRICE_B     = 20,
  parameter int MAX_CREDIT  = 45,
  parameter int CHANGE_COIN = 5,
  parameter int ACK_TO      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic [1:0]          sel,
  input  logic                cancel,
  input  logic                dispense_ack,
  output logic                pr_en,
  output logic                pr_sel,
  output logic                chg_en,
  output logic                coin_rej,
  output logic                fault,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int CNT_W = $clog2(ACK_TO + 1);
  localparam logic [CREDIT_W-1:0] P_A     = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] P_B     = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W-1:0] P_CHG   = CREDIT_W'(CHANGE_COIN);
  localparam logic [CREDIT_W:0]   P_MAX   = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CNT_W-1:0]    TO_LAST = CNT_W'(ACK_TO - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] coin_add;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W-1:0] vend_price;
  logic                coin_valid;
  logic                coin_fits;
  logic                cancel_acc;
  logic                coin_acc;
  logic                sel_ok;
  logic                buy;

  always_comb begin
    coin_val = '0;
    case (coin)
      2'b01:   coin_val = CREDIT_W'(5);
      2'b10:   coin_val = CREDIT_W'(10);
      default: coin_val = '0;
    endcase
  end

  assign coin_valid = (coin == 2'b01) || (coin == 2'b10);
  // Fit check uses registered credit, so a refund after an aborted vend stays within MAX_CREDIT.
  assign coin_fits  = ({1'b0, credit} + {1'b0, coin_val}) <= P_MAX;
  assign cancel_acc = (state == COLLECT) && cancel;
  assign coin_acc   = coin_valid && ((state == IDLE) || (state == COLLECT)) &&
                      !cancel_acc && coin_fits;
  assign coin_add   = coin_acc ? coin_val : '0;
  assign sel_ok     = (sel == 2'b01) || (sel == 2'b10);
  assign sel_price  = (sel == 2'b10) ? P_B : P_A;
  assign vend_price = pr_sel ? P_B : P_A;
  assign buy        = (state == COLLECT) && !cancel && sel_ok && (credit >= sel_price);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      credit   <= '0;
      pr_en    <= 1'b0;
      pr_sel   <= 1'b0;
      chg_en   <= 1'b0;
      coin_rej <= 1'b0;
      fault    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      coin_rej <= (coin != 2'b00) && !coin_acc;
      chg_en   <= 1'b0;
      fault    <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_acc) begin
            credit <= credit + coin_add;
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (cancel_acc) begin
            state <= CHANGE;
            busy  <= 1'b1;
          end else if (buy) begin
            state  <= VEND;
            busy   <= 1'b1;
            pr_en  <= 1'b1;
            pr_sel <= (sel == 2'b10);
            credit <= credit - sel_price + coin_add;
            cnt    <= '0;
          end else begin
            credit <= credit + coin_add;
          end
        end
        VEND: begin
          // Ack is checked first so an ack in the final timeout cycle still completes the sale.
          if (dispense_ack) begin
            pr_en <= 1'b0;
            cnt   <= '0;
            if (credit != '0) begin
              state <= CHANGE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (cnt == TO_LAST) begin
            pr_en  <= 1'b0;
            fault  <= 1'b1;
            credit <= credit + vend_price;
            cnt    <= '0;
            state  <= CHANGE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHANGE: begin
          if (credit != '0) begin
            chg_en <= 1'b1;
            credit <= credit - P_CHG;
            if (credit == P_CHG) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
